branch_resolve_ctrl: RTL

Sequencer for the ID-stage branch comparator. It accepts a decoded branch and holds ID while either source register is still being produced in EX/MEM. It then drives the comparator's 3-bit control, samples the comparator's 1-bit result, and issues a one-cycle PC redirect plus IF/ID flush for taken branches. It sits between the ID decoder, the hazard/forwarding path, and the PC-select mux.

---
 rtl/branch_ctrl_pkg.sv | 31 +++
 rtl/branch_resolve_ctrl_if.sv | 39 +++
 rtl/branch_hazard_detect.sv | 36 +++
 rtl/branch_resolve_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared types for the ID-stage branch resolve sequencer: comparator op
// encodings, FSM state enum and the hazard wait-count type.
package branch_ctrl_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BGEZ = 3'b001;
  localparam logic [2:0] OP_BGTZ = 3'b010;
  localparam logic [2:0] OP_BLEZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    EVAL     = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  typedef logic [1:0] wait_cnt_t;

  // Ops 110/111 have no comparator meaning and never resolve taken.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_BNE;
  endfunction

  // Rt is only compared for the two-register branches.
  function automatic logic op_uses_rt(input logic [2:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bus between the ID decoder / hazard path / comparator / PC mux and the
// branch resolve sequencer.
interface branch_resolve_ctrl_if #(parameter int WIDTH = 32);
  logic             BranchValid;
  logic [2:0]       BranchOp;
  logic [4:0]       RsAddr;
  logic [4:0]       RtAddr;
  logic [WIDTH-1:0] Target;
  logic             ExRegWrite;
  logic             ExMemRead;
  logic [4:0]       ExDest;
  logic             MemRegWrite;
  logic             MemMemRead;
  logic [4:0]       MemDest;
  logic             CmpResult;
  logic [2:0]       CmpControl;
  logic             Stall;
  logic             Redirect;
  logic [WIDTH-1:0] RedirectPC;
  logic             Flush;
  logic [31:0]      BranchCount;
  logic [31:0]      TakenCount;

  modport master (
    output BranchValid, BranchOp, RsAddr, RtAddr, Target,
           ExRegWrite, ExMemRead, ExDest, MemRegWrite, MemMemRead, MemDest,
           CmpResult,
    input  CmpControl, Stall, Redirect, RedirectPC, Flush,
           BranchCount, TakenCount
  );

  modport slave (
    input  BranchValid, BranchOp, RsAddr, RtAddr, Target,
           ExRegWrite, ExMemRead, ExDest, MemRegWrite, MemMemRead, MemDest,
           CmpResult,
    output CmpControl, Stall, Redirect, RedirectPC, Flush,
           BranchCount, TakenCount
  );
endinterface

// File: rtl/branch_hazard_detect.sv
// Combinational hazard wait count for a branch in ID: the number of cycles
// its sources still need from EX/MEM (max over used sources).
module branch_hazard_detect
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  input  logic       mem_reg_write,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dest,
  output wait_cnt_t  wait_cnt
);

  function automatic wait_cnt_t src_wait(input logic [4:0] src);
    if (src == 5'd0)                                             return 2'd0;
    if (ex_reg_write && ex_mem_read && (ex_dest == src))         return 2'd2;
    if (ex_reg_write && (ex_dest == src))                        return 2'd1;
    if (mem_reg_write && mem_mem_read && (mem_dest == src))      return 2'd1;
    return 2'd0;
  endfunction

  // Max of the per-source waits; illegal ops never stall.
  always_comb begin
    wait_cnt_t rs_w;
    wait_cnt_t rt_w;
    rs_w     = src_wait(rs_addr);
    rt_w     = op_uses_rt(branch_op) ? src_wait(rt_addr) : 2'd0;
    wait_cnt = '0;
    if (op_is_legal(branch_op)) wait_cnt = (rs_w > rt_w) ? rs_w : rt_w;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolve sequencer: stalls on EX/MEM source hazards, drives
// the comparator, and issues a one-cycle redirect/flush for taken branches.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  branch_resolve_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  wait_cnt_t        wait_cnt_q, wait_cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             stall;
  logic [2:0]       cmp_ctrl;
  wait_cnt_t        hz_wait;

  branch_hazard_detect u_hazard (
    .branch_op     (bus.BranchOp),
    .rs_addr       (bus.RsAddr),
    .rt_addr       (bus.RtAddr),
    .ex_reg_write  (bus.ExRegWrite),
    .ex_mem_read   (bus.ExMemRead),
    .ex_dest       (bus.ExDest),
    .mem_reg_write (bus.MemRegWrite),
    .mem_mem_read  (bus.MemMemRead),
    .mem_dest      (bus.MemDest),
    .wait_cnt      (hz_wait)
  );

  // Next-state, latched branch context and combinational stall/control.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    op_d          = op_q;
    target_d      = target_q;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    stall         = 1'b0;
    cmp_ctrl      = 3'b000;
    unique case (state_q)
      IDLE: begin
        cmp_ctrl = bus.BranchOp;
        if (bus.BranchValid) begin
          if (hz_wait != 2'd0) begin
            // The IDLE cycle is itself the first stall cycle, so WAIT only
            // covers the remaining hazard cycles (none for a 1-cycle hazard).
            stall    = 1'b1;
            op_d     = bus.BranchOp;
            target_d = bus.Target;
            if (hz_wait == 2'd1) begin
              wait_cnt_d = '0;
              state_d    = EVAL;
            end else begin
              wait_cnt_d = hz_wait - 2'd1;
              state_d    = WAIT;
            end
          end else if (bus.CmpResult && op_is_legal(bus.BranchOp)) begin
            target_d      = bus.Target;
            redirect_d    = 1'b1;
            redirect_pc_d = bus.Target;
            state_d       = REDIRECT;
          end
        end
      end
      WAIT: begin
        stall      = 1'b1;
        cmp_ctrl   = op_q;
        wait_cnt_d = wait_cnt_q - 2'd1;
        if (wait_cnt_q == 2'd1) state_d = EVAL;
      end
      EVAL: begin
        cmp_ctrl = op_q;
        if (bus.CmpResult && op_is_legal(op_q)) begin
          redirect_d    = 1'b1;
          redirect_pc_d = target_q;
          state_d       = REDIRECT;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and registered redirect outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      op_q          <= '0;
      target_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      op_q          <= op_d;
      target_q      <= target_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.CmpControl = cmp_ctrl;
  assign bus.Stall      = stall;
  assign bus.Redirect   = redirect_q;
  assign bus.Flush      = redirect_q;
  assign bus.RedirectPC = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] taken_count_q, taken_count_d;
  logic        resolved;

  // Saturating per-branch and per-taken counters.
  always_comb begin
    resolved       = ((state_q == IDLE) && bus.BranchValid && (hz_wait == 2'd0))
                     || (state_q == EVAL);
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (resolved && (branch_count_q != '1)) branch_count_d = branch_count_q + 32'd1;
    if (redirect_d && (taken_count_q != '1)) taken_count_d = taken_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign bus.BranchCount = branch_count_q;
  assign bus.TakenCount  = taken_count_q;
`else
  assign bus.BranchCount = '0;
  assign bus.TakenCount  = '0;
`endif

endmodule
